alu_result_stage: RTL and testbench

Pipeline register stage directly downstream of the ALU comparison/LUI sub-unit. Captures RESULT, EQUAL and SMALL with destination-register info, resolves the branch condition, and presents one registered entry to the memory stage. Uses a valid/ready handshake with a 2-entry skid buffer so IN_READY is a registered signal. Also keeps a saturating back-pressure stall counter for performance debug.

---
 rtl/alu_result_stage_if.sv | 37 +++
 rtl/alu_result_stage.sv | 118 +++++++++++
 tb/tb_alu_result_stage.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/alu_result_stage_if.sv
// Handshake bundle between the ALU compare/LUI unit, the result stage
// and the memory stage.
interface alu_result_stage_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] RESULT;
    logic             EQUAL;
    logic             SMALL;
    logic [4:0]       RD;
    logic             REG_WE;
    logic [1:0]       BR_OP;
    logic             FLUSH;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [WIDTH-1:0] OUT_RESULT;
    logic [4:0]       OUT_RD;
    logic             OUT_WE;
    logic             BR_TAKEN;
    logic [CNT_W-1:0] STALL_CNT;

    modport master (
        output IN_VALID, RESULT, EQUAL, SMALL, RD, REG_WE, BR_OP,
        output FLUSH, OUT_READY,
        input  IN_READY, OUT_VALID, OUT_RESULT, OUT_RD, OUT_WE,
        input  BR_TAKEN, STALL_CNT
    );

    modport slave (
        input  IN_VALID, RESULT, EQUAL, SMALL, RD, REG_WE, BR_OP,
        input  FLUSH, OUT_READY,
        output IN_READY, OUT_VALID, OUT_RESULT, OUT_RD, OUT_WE,
        output BR_TAKEN, STALL_CNT
    );
endinterface

// File: rtl/alu_result_stage.sv
// ALU result pipeline register: 2-entry skid buffer with branch resolution
// at capture and a saturating back-pressure stall counter.
module alu_result_stage #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input logic              CLK,
    input logic              RSTN,
    alu_result_stage_if.slave io
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_e;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [4:0]       rd;
        logic             we;
        logic             br;
    } entry_t;

    occ_e             state_q, state_d;
    entry_t           h_q, h_d;
    entry_t           s_q, s_d;
    logic             in_ready_q, in_ready_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    entry_t in_entry;
    logic   taken;
    logic   accept;
    logic   consume;

    always_comb begin
        taken = 1'b0;
        case (io.BR_OP)
            2'b01:   taken = io.EQUAL;
            2'b10:   taken = ~io.EQUAL;
            2'b11:   taken = io.SMALL;
            default: taken = 1'b0;
        endcase
        in_entry.result = io.RESULT;
        in_entry.rd     = io.RD;
        in_entry.we     = io.REG_WE;
        in_entry.br     = taken;
    end

    assign accept  = io.IN_VALID & in_ready_q;
    assign consume = (state_q != EMPTY) & io.OUT_READY;

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        s_d     = s_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    h_d     = in_entry;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (accept && consume) begin
                    h_d = in_entry;
                end else if (accept) begin
                    s_d     = in_entry;
                    state_d = FULL;
                end else if (consume) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (consume) begin
                    h_d     = s_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush drops occupancy only; stale data is masked by OUT_VALID=0.
        if (io.FLUSH) begin
            state_d = EMPTY;
        end
        in_ready_d = (state_d != FULL);
    end

    always_comb begin
        stall_d = stall_q;
        if ((state_q != EMPTY) && !io.OUT_READY && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q    <= EMPTY;
            h_q        <= '0;
            s_q        <= '0;
            in_ready_q <= 1'b1;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            h_q        <= h_d;
            s_q        <= s_d;
            in_ready_q <= in_ready_d;
            stall_q    <= stall_d;
        end
    end

    assign io.IN_READY   = in_ready_q;
    assign io.OUT_VALID  = (state_q != EMPTY);
    assign io.OUT_RESULT = h_q.result;
    assign io.OUT_RD     = h_q.rd;
    assign io.OUT_WE     = h_q.we;
    assign io.BR_TAKEN   = h_q.br & (state_q != EMPTY);
    assign io.STALL_CNT  = stall_q;
endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: reset, streaming, back-pressure,
// branch decode, flush and stall-counter saturation.
module tb_alu_result_stage;
    localparam int WIDTH = 32;
    localparam int CNT_W = 4;

    logic CLK;
    logic RSTN;
    int   total;
    int   fails;

    alu_result_stage_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    alu_result_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .CLK (CLK),
        .RSTN(RSTN),
        .io  (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] r, input logic [1:0] op,
                        input logic eq, input logic sm);
        bus.IN_VALID = 1'b1;
        bus.RESULT   = r;
        bus.BR_OP    = op;
        bus.EQUAL    = eq;
        bus.SMALL    = sm;
        bus.RD       = r[4:0];
        bus.REG_WE   = 1'b1;
    endtask

    initial begin
        total = 0;
        fails = 0;
        RSTN          = 1'b0;
        bus.FLUSH     = 1'b0;
        bus.OUT_READY = 1'b0;
        send(32'd99, 2'b01, 1'b1, 1'b1);

        // reset with IN_VALID asserted
        tick();
        tick();
        chk("rst_out_valid", bus.OUT_VALID, 1'b0);
        chk("rst_in_ready", bus.IN_READY, 1'b1);
        chk("rst_stall", bus.STALL_CNT, 0);
        chk("rst_result", bus.OUT_RESULT, 0);
        chk("rst_rd", bus.OUT_RD, 0);
        chk("rst_we", bus.OUT_WE, 1'b0);
        chk("rst_br", bus.BR_TAKEN, 1'b0);

        // streaming 1,2,3
        RSTN          = 1'b1;
        bus.OUT_READY = 1'b1;
        send(32'd1, 2'b00, 1'b0, 1'b0);
        tick();
        chk("str1_valid", bus.OUT_VALID, 1'b1);
        chk("str1_result", bus.OUT_RESULT, 1);
        chk("str1_rd", bus.OUT_RD, 1);
        chk("str1_we", bus.OUT_WE, 1'b1);
        send(32'd2, 2'b00, 1'b0, 1'b0);
        tick();
        chk("str2_result", bus.OUT_RESULT, 2);
        chk("str2_in_ready", bus.IN_READY, 1'b1);
        send(32'd3, 2'b00, 1'b0, 1'b0);
        tick();
        chk("str3_result", bus.OUT_RESULT, 3);
        chk("str3_in_ready", bus.IN_READY, 1'b1);
        bus.IN_VALID = 1'b0;
        tick();
        chk("str_drain", bus.OUT_VALID, 1'b0);
        chk("str_stall", bus.STALL_CNT, 0);

        // back-pressure A, B, C held upstream
        bus.OUT_READY = 1'b0;
        send(32'hA, 2'b00, 1'b0, 1'b0);
        tick();
        chk("bp_a_head", bus.OUT_RESULT, 32'hA);
        chk("bp_one_ready", bus.IN_READY, 1'b1);
        send(32'hB, 2'b00, 1'b0, 1'b0);
        tick();
        chk("bp_full_ready", bus.IN_READY, 1'b0);
        chk("bp_full_head", bus.OUT_RESULT, 32'hA);
        chk("bp_stall1", bus.STALL_CNT, 1);
        send(32'hC, 2'b00, 1'b0, 1'b0);
        tick();
        tick();
        chk("bp_hold_head", bus.OUT_RESULT, 32'hA);
        chk("bp_hold_ready", bus.IN_READY, 1'b0);
        chk("bp_stall3", bus.STALL_CNT, 3);
        bus.OUT_READY = 1'b1;
        tick();
        chk("bp_out_b", bus.OUT_RESULT, 32'hB);
        chk("bp_b_ready", bus.IN_READY, 1'b1);
        tick();
        chk("bp_out_c", bus.OUT_RESULT, 32'hC);
        chk("bp_c_valid", bus.OUT_VALID, 1'b1);
        bus.IN_VALID = 1'b0;
        tick();
        chk("bp_drain", bus.OUT_VALID, 1'b0);
        chk("bp_stall_final", bus.STALL_CNT, 3);

        // branch decode
        send(32'h10, 2'b01, 1'b1, 1'b0);
        tick();
        chk("br_beq_eq", bus.BR_TAKEN, 1'b1);
        send(32'h11, 2'b10, 1'b1, 1'b0);
        tick();
        chk("br_bne_eq", bus.BR_TAKEN, 1'b0);
        send(32'h12, 2'b11, 1'b0, 1'b1);
        tick();
        chk("br_small", bus.BR_TAKEN, 1'b1);
        send(32'h13, 2'b00, 1'b1, 1'b1);
        tick();
        chk("br_none", bus.BR_TAKEN, 1'b0);
        send(32'h14, 2'b10, 1'b0, 1'b0);
        tick();
        chk("br_bne_ne", bus.BR_TAKEN, 1'b1);
        send(32'h15, 2'b01, 1'b0, 1'b1);
        tick();
        chk("br_beq_ne", bus.BR_TAKEN, 1'b0);
        send(32'h16, 2'b01, 1'b1, 1'b0);
        tick();
        chk("br_beq_eq2", bus.BR_TAKEN, 1'b1);
        bus.IN_VALID = 1'b0;
        tick();
        chk("br_invalid", bus.BR_TAKEN, 1'b0);

        // flush from FULL with an incoming entry
        bus.OUT_READY = 1'b0;
        send(32'h11, 2'b01, 1'b1, 1'b0);
        tick();
        send(32'h22, 2'b01, 1'b1, 1'b0);
        tick();
        chk("fl_full_ready", bus.IN_READY, 1'b0);
        chk("fl_pre_br", bus.BR_TAKEN, 1'b1);
        send(32'h33, 2'b01, 1'b1, 1'b0);
        bus.FLUSH = 1'b1;
        tick();
        chk("fl_valid", bus.OUT_VALID, 1'b0);
        chk("fl_ready", bus.IN_READY, 1'b1);
        chk("fl_br", bus.BR_TAKEN, 1'b0);
        chk("fl_stall", bus.STALL_CNT, 5);
        bus.FLUSH     = 1'b0;
        bus.IN_VALID  = 1'b0;
        bus.OUT_READY = 1'b1;
        tick();
        chk("fl_no_ghost", bus.OUT_VALID, 1'b0);
        send(32'h44, 2'b00, 1'b0, 1'b0);
        tick();
        chk("fl_recover", bus.OUT_RESULT, 32'h44);
        bus.IN_VALID = 1'b0;
        tick();

        // saturation of the 4-bit stall counter
        RSTN = 1'b0;
        tick();
        chk("sat_rst", bus.STALL_CNT, 0);
        RSTN          = 1'b1;
        bus.OUT_READY = 1'b0;
        send(32'h55, 2'b00, 1'b0, 1'b0);
        tick();
        bus.IN_VALID = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("sat_15", bus.STALL_CNT, 15);
        chk("sat_hold_data", bus.OUT_RESULT, 32'h55);
        chk("sat_hold_valid", bus.OUT_VALID, 1'b1);
        tick();
        chk("sat_stays", bus.STALL_CNT, 15);
        RSTN = 1'b0;
        tick();
        chk("sat_mid_rst", bus.STALL_CNT, 0);
        chk("sat_rst_valid", bus.OUT_VALID, 1'b0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
